inst_fetch_queue: RTL

//  Parametrised fetch unit: issues pipelined bus reads (address phase, then data phase), buffers

---
 rtl/inst_fetch_queue.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: pipelined bus reads into a DEPTH-entry FIFO of {inst, PC}, handed to decode via valid/ready.
// Optional JAL pre-decode and predicted redirect is enabled by defining IF_JAL_PREDICT_EN.
module inst_fetch_queue #(
  parameter int               XLEN     = 64,
  parameter int               ILEN     = 32,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic             CLK,
  input  logic             reset,
  output logic [XLEN-1:0]  HADDR,
  output logic             HTRANS,
  input  logic             HREADY,
  input  logic [XLEN-1:0]  HRDATA,
  input  logic             take_branch,
  input  logic [XLEN-1:0]  branch_PC,
  input  logic [XLEN-1:0]  take_branch_offset,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [ILEN-1:0]  inst,
  output logic [XLEN-1:0]  inst_PC,
  output logic             inst_pred_taken
);

  localparam int              AW         = $clog2(DEPTH);
  localparam int              LANES      = XLEN / ILEN;
  localparam int              LW         = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int              LB         = $clog2(ILEN / 8);
  localparam logic [XLEN-1:0] STEP       = XLEN'(ILEN / 8);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(STEP - XLEN'(1));
  localparam logic [ILEN-1:0] NOP        = ILEN'(32'h0000_0013);

  logic                       run;
  logic [XLEN-1:0]            fetch_pc;
  logic                       epoch;
  logic                       dp_valid;
  logic                       dp_epoch;
  logic [XLEN-1:0]            dp_addr;
  logic [AW:0]                wr_ptr;
  logic [AW:0]                rd_ptr;
  logic [AW:0]                rd_next;
  logic [AW:0]                count;
  logic [ILEN-1:0]            mem_inst [DEPTH];
  logic [XLEN-1:0]            mem_pc   [DEPTH];
  logic                       mem_pred [DEPTH];
  logic [ILEN-1:0]            last_inst;
  logic [XLEN-1:0]            last_pc;
  logic                       last_pred;
  logic [LANES-1:0][ILEN-1:0] words;
  logic [LW-1:0]              lane;
  logic [ILEN-1:0]            beat_inst;
  logic                       accept;
  logic                       beat_done;
  logic                       push;
  logic                       pop;
  logic                       jal_hit;
  logic [XLEN-1:0]            jal_target;
  logic [XLEN-1:0]            branch_target;

  assign count      = wr_ptr - rd_ptr;
  assign inst_valid = (wr_ptr != rd_ptr);
  assign pop        = inst_valid && inst_ready;
  assign rd_next    = rd_ptr + {{AW{1'b0}}, pop};

  // Credit rule: a beat is only requested if a FIFO slot is reserved for it, so push never overflows.
  assign HTRANS    = run && !take_branch && ((int'(count) + int'(dp_valid)) < DEPTH);
  assign HADDR     = fetch_pc;
  assign accept    = HTRANS && HREADY;
  assign beat_done = dp_valid && HREADY;
  assign push      = beat_done && (dp_epoch == epoch) && !take_branch;

  assign words         = HRDATA;
  assign lane          = (LANES > 1) ? dp_addr[LB +: LW] : '0;
  assign beat_inst     = words[lane];
  assign branch_target = (branch_PC + take_branch_offset) & ALIGN_MASK;

`ifdef IF_JAL_PREDICT_EN
  logic [XLEN-1:0] jal_imm;
  assign jal_imm = {{(XLEN-21){beat_inst[31]}}, beat_inst[31], beat_inst[19:12],
                    beat_inst[20], beat_inst[30:21], 1'b0};
`endif

  // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    jal_hit    = 1'b0;
    jal_target = '0;
`ifdef IF_JAL_PREDICT_EN
    if (push && beat_inst[6:0] == 7'b1101111) begin
      jal_hit    = 1'b1;
      jal_target = (dp_addr + jal_imm) & ALIGN_MASK;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      run       <= 1'b0;
      fetch_pc  <= RESET_PC;
      epoch     <= 1'b0;
      dp_valid  <= 1'b0;
      dp_epoch  <= 1'b0;
      dp_addr   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      last_inst <= NOP;
      last_pc   <= '0;
      last_pred <= 1'b0;
    end else begin
      run      <= 1'b1;
      dp_valid <= accept || (dp_valid && !HREADY);
      if (accept) begin
        dp_addr  <= fetch_pc;
        dp_epoch <= epoch;
      end
      // Redirect beats JAL prediction beats sequential fetch; an epoch toggle kills beats in flight.
      if (take_branch) begin
        fetch_pc <= branch_target;
        epoch    <= ~epoch;
      end else if (jal_hit) begin
        fetch_pc <= jal_target;
        epoch    <= ~epoch;
      end else if (accept) begin
        fetch_pc <= fetch_pc + STEP;
      end
      rd_ptr <= rd_next;
      if (take_branch)
        wr_ptr <= rd_next;
      else if (push)
        wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (inst_valid) begin
        last_inst <= inst;
        last_pc   <= inst_PC;
        last_pred <= inst_pred_taken;
      end
    end
  end

  // NOTE: the storage array carries no reset; pointers alone define which entries are meaningful.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_inst[wr_ptr[AW-1:0]] <= beat_inst;
      mem_pc[wr_ptr[AW-1:0]]   <= dp_addr;
      mem_pred[wr_ptr[AW-1:0]] <= jal_hit;
    end
  end

  // While empty the outputs hold whatever was last presented at the head.
  assign inst            = inst_valid ? mem_inst[rd_ptr[AW-1:0]] : last_inst;
  assign inst_PC         = inst_valid ? mem_pc[rd_ptr[AW-1:0]]   : last_pc;
  assign inst_pred_taken = inst_valid ? mem_pred[rd_ptr[AW-1:0]] : last_pred;

endmodule
